muldiv_ctrl: RTL and testbench

- Sequencer for the RV32M datapath.
- Accepts one M-extension operation at a time from the ALU.
- Resolves divide-by-zero and signed-overflow cases, and serves repeated div/rem pairs from a one-entry cache, without starting a core.
- Otherwise drives the shared unsigned multi-cycle mul and div cores with operand magnitudes, then applies the sign fix-up and returns one 32-bit result.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_signfix.sv | 31 +++
 rtl/muldiv_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MUL_WAIT,
    ST_DIV_WAIT,
    ST_FIX,
    ST_DRAIN
  } state_e;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // Unsigned magnitude of an operand that may be a negative signed value.
  function automatic logic [31:0] mag(input logic [31:0] v, input logic neg);
    return neg ? (32'd0 - v) : v;
  endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Sign fix-up of raw unsigned core results and final result word selection.
module muldiv_signfix
  import muldiv_pkg::*;
(
  input  op_e         op_i,
  input  logic [63:0] prod_i,
  input  logic [31:0] quo_i,
  input  logic [31:0] rem_i,
  input  logic        s1neg_i,
  input  logic        s2neg_i,
  output logic [31:0] result_o,
  output logic [31:0] quo_o,
  output logic [31:0] rem_o
);

  logic [63:0] prod_fix;

  always_comb begin
    prod_fix = (s1neg_i ^ s2neg_i) ? (64'd0 - prod_i) : prod_i;
    quo_o    = (s1neg_i ^ s2neg_i) ? (32'd0 - quo_i) : quo_i;
    // Remainder takes the sign of the dividend.
    rem_o    = s1neg_i ? (32'd0 - rem_i) : rem_i;
    case (op_i)
      OP_MUL:                      result_o = prod_fix[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result_o = prod_fix[63:32];
      OP_DIV, OP_DIVU:             result_o = quo_o;
      default:                     result_o = rem_o;
    endcase
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// RV32M sequencer: special-case and cached div/rem fast path, otherwise drives
// the shared unsigned mul/div cores and applies the sign fix-up.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter bit CACHE_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic        flush,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic        mul_enable,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic        mul_completed,
  input  logic [63:0] mul_product,
  output logic        div_enable,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_completed,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder
);

  state_e      state_q;
  op_e         op_q;
  logic        s1neg_q, s2neg_q;
  logic [63:0] prod_q;
  logic [31:0] quo_q, rem_q;
  logic        resp_valid_q, mul_en_q, div_en_q;
  logic [31:0] resp_data_q, mul_a_q, mul_b_q, dvd_q, dvs_q;
  logic        c_vld_q, c_sgn_q;
  logic [31:0] c_rs1_q, c_rs2_q, c_quo_q, c_rem_q;

  op_e         op_d;
  logic        s1neg_d, s2neg_d;
  logic        accept, is_div, div_sgn, is_rem, by_zero, ovf, hit, fast_d;
  logic [31:0] fast_data_d;
  logic [31:0] fix_result, fix_quo, fix_rem;

  assign op_d    = op_e'(req_op);
  assign req_ready = (state_q == ST_IDLE) & ~flush;
  assign accept  = req_valid & req_ready;
  assign is_div  = req_op[2];
  assign div_sgn = ~req_op[0];
  assign is_rem  = req_op[1];
  assign by_zero = is_div & (req_rs2 == 32'd0);
  assign ovf     = is_div & div_sgn & (req_rs1 == INT_MIN) & (req_rs2 == ALL_ONES);
  assign hit     = CACHE_EN & is_div & c_vld_q & (req_rs1 == c_rs1_q) &
                   (req_rs2 == c_rs2_q) & (div_sgn == c_sgn_q);
  assign fast_d  = by_zero | ovf | hit;

  always_comb begin
    s1neg_d = 1'b0;
    s2neg_d = 1'b0;
    case (op_d)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: begin
        s1neg_d = req_rs1[31];
        s2neg_d = req_rs2[31];
      end
      OP_MULHSU: s1neg_d = req_rs1[31];
      default: ;
    endcase
    // Zero divisor outranks overflow, which outranks the cache.
    if (by_zero)  fast_data_d = is_rem ? req_rs1 : ALL_ONES;
    else if (ovf) fast_data_d = is_rem ? 32'd0 : INT_MIN;
    else          fast_data_d = is_rem ? c_rem_q : c_quo_q;
  end

  muldiv_signfix u_signfix (
    .op_i    (op_q),
    .prod_i  (prod_q),
    .quo_i   (quo_q),
    .rem_i   (rem_q),
    .s1neg_i (s1neg_q),
    .s2neg_i (s2neg_q),
    .result_o(fix_result),
    .quo_o   (fix_quo),
    .rem_o   (fix_rem)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_MUL;
      s1neg_q      <= 1'b0;
      s2neg_q      <= 1'b0;
      prod_q       <= '0;
      quo_q        <= '0;
      rem_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      mul_en_q     <= 1'b0;
      div_en_q     <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
      dvd_q        <= '0;
      dvs_q        <= 32'd1;
      c_vld_q      <= 1'b0;
      c_sgn_q      <= 1'b0;
      c_rs1_q      <= '0;
      c_rs2_q      <= '0;
      c_quo_q      <= '0;
      c_rem_q      <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      mul_en_q     <= 1'b0;
      div_en_q     <= 1'b0;
      case (state_q)
        ST_IDLE: if (accept) begin
          if (fast_d) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= fast_data_d;
          end else begin
            op_q    <= op_d;
            s1neg_q <= s1neg_d;
            s2neg_q <= s2neg_d;
            if (is_div) begin
              dvd_q    <= mag(req_rs1, s1neg_d);
              dvs_q    <= mag(req_rs2, s2neg_d);
              div_en_q <= 1'b1;
              state_q  <= ST_DIV_WAIT;
            end else begin
              mul_a_q  <= mag(req_rs1, s1neg_d);
              mul_b_q  <= mag(req_rs2, s2neg_d);
              mul_en_q <= 1'b1;
              state_q  <= ST_MUL_WAIT;
            end
          end
        end
        // A flush coinciding with the done pulse has nothing left to drain.
        ST_MUL_WAIT: begin
          if (mul_completed) begin
            prod_q  <= mul_product;
            state_q <= flush ? ST_IDLE : ST_FIX;
          end else if (flush) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_DIV_WAIT: begin
          if (div_completed) begin
            quo_q   <= div_quotient;
            rem_q   <= div_remainder;
            state_q <= flush ? ST_IDLE : ST_FIX;
          end else if (flush) begin
            state_q <= ST_DRAIN;
          end
        end
        ST_FIX: begin
          state_q <= ST_IDLE;
          if (!flush) begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= fix_result;
            if (op_q[2]) begin
              c_vld_q <= CACHE_EN;
              c_sgn_q <= ~op_q[0];
              c_rs1_q <= s1neg_q ? (32'd0 - dvd_q) : dvd_q;
              c_rs2_q <= s2neg_q ? (32'd0 - dvs_q) : dvs_q;
              c_quo_q <= fix_quo;
              c_rem_q <= fix_rem;
            end
          end
        end
        ST_DRAIN: if (op_q[2] ? div_completed : mul_completed) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign resp_valid   = resp_valid_q;
  assign resp_data    = resp_data_q;
  assign mul_enable   = mul_en_q;
  assign mul_a        = mul_a_q;
  assign mul_b        = mul_b_q;
  assign div_enable   = div_en_q;
  assign div_dividend = dvd_q;
  assign div_divisor  = dvs_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: one instance with the cache, one without, sharing stimulus.
module tb_muldiv_ctrl;
  import muldiv_pkg::*;

  logic        clk = 1'b0, rstn = 1'b0;
  logic        req_valid = 1'b0, flush = 1'b0;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_rs1 = '0, req_rs2 = '0;

  logic        req_ready[2], resp_valid[2], mul_enable[2], div_enable[2];
  logic        mul_completed[2], div_completed[2];
  logic [31:0] resp_data[2], mul_a[2], mul_b[2], div_dividend[2], div_divisor[2];
  logic [31:0] div_quotient[2], div_remainder[2];
  logic [63:0] mul_product[2];
  int          mcnt[2], dcnt[2];

  int lat = 1;
  int n_chk = 0, n_fail = 0;

  // Cache model: last div-family operation that finished unflushed.
  bit          c_vld = 1'b0, c_sgn = 1'b0;
  logic [31:0] c_rs1 = '0, c_rs2 = '0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic        mcomp = 1'b0, dcomp = 1'b0;
    logic [63:0] mres = '0, mprod = '0;
    logic [31:0] qres = '0, rres = '0, dq = '0, dr = '0;
    int          mc = 0, dc = 0, mn = 0, dn = 0;

    muldiv_ctrl #(.CACHE_EN(g == 0)) u_dut (
      .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_ready(req_ready[g]),
      .req_op(req_op), .req_rs1(req_rs1), .req_rs2(req_rs2), .flush(flush),
      .resp_valid(resp_valid[g]), .resp_data(resp_data[g]),
      .mul_enable(mul_enable[g]), .mul_a(mul_a[g]), .mul_b(mul_b[g]),
      .mul_completed(mul_completed[g]), .mul_product(mul_product[g]),
      .div_enable(div_enable[g]), .div_dividend(div_dividend[g]), .div_divisor(div_divisor[g]),
      .div_completed(div_completed[g]), .div_quotient(div_quotient[g]),
      .div_remainder(div_remainder[g])
    );

    // Behavioural cores: done pulse 'lat' cycles after the start pulse; not reset.
    always @(posedge clk) begin
      mcomp <= 1'b0;
      dcomp <= 1'b0;
      if (mul_enable[g]) begin
        mn <= mn + 1; mc <= lat;
        mres <= {32'd0, mul_a[g]} * {32'd0, mul_b[g]};
      end else if (mc > 0) begin
        mc <= mc - 1;
        if (mc == 1) begin mcomp <= 1'b1; mprod <= mres; end
      end
      if (div_enable[g]) begin
        dn <= dn + 1; dc <= lat;
        qres <= div_dividend[g] / div_divisor[g];
        rres <= div_dividend[g] % div_divisor[g];
      end else if (dc > 0) begin
        dc <= dc - 1;
        if (dc == 1) begin dcomp <= 1'b1; dq <= qres; dr <= rres; end
      end
    end

    assign mul_completed[g] = mcomp;
    assign div_completed[g] = dcomp;
    assign mul_product[g]   = mprod;
    assign div_quotient[g]  = dq;
    assign div_remainder[g] = dr;
    assign mcnt[g]          = mn;
    assign dcnt[g]          = dn;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // RV32M semantics from plain integer arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, b);
    int          ia, ib;
    longint      sa, sb, ua, ub, p;
    logic [31:0] r;
    ia = a; ib = b;
    sa = ia; sb = ib;
    ua = {32'd0, a}; ub = {32'd0, b};
    p = 0;
    case (op)
      3'd0: begin p = sa * sb; r = p[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * ub; r = p[63:32]; end
      3'd3: begin p = ua * ub; r = p[63:32]; end
      3'd4: if (b == 0) r = ALL_ONES; else if (a == INT_MIN && b == ALL_ONES) r = INT_MIN; else r = ia / ib;
      3'd5: if (b == 0) r = ALL_ONES; else r = a / b;
      3'd6: if (b == 0) r = a; else if (a == INT_MIN && b == ALL_ONES) r = 32'd0; else r = ia % ib;
      default: if (b == 0) r = a; else r = a % b;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return INT_MIN;
      2: return ALL_ONES;
      3: return $urandom_range(0, 15);
      4: return 32'd0 - $urandom_range(1, 15);
      default: return $urandom;
    endcase
  endfunction

  // One request to both instances; fl_dly >= 0 raises flush that many cycles after acceptance.
  task automatic do_req(input string nm, input logic [2:0] op, input logic [31:0] a, b,
                        input int fl_dly_i, input int lat_i,
                        output logic [31:0] got0, output int st0, output int st1);
    logic [31:0] exp;
    logic [31:0] got[2];
    bit          spec, hit, fast[2], want[2], comp[2], early[2], done;
    int          nresp[2], rlat[2], m0[2], d0[2], n, tail, fl_dly;
    fl_dly = fl_dly_i;
    exp  = ref_result(op, a, b);
    spec = op[2] && (b == 0 || (!op[0] && a == INT_MIN && b == ALL_ONES));
    hit  = op[2] && c_vld && a == c_rs1 && b == c_rs2 && c_sgn == !op[0];
    fast[0] = spec || hit;
    fast[1] = spec;
    if (spec) fl_dly = -1;
    for (int g = 0; g < 2; g++) begin
      want[g] = fast[g] || fl_dly < 0;
      nresp[g] = 0; rlat[g] = 0; comp[g] = 0; early[g] = 0; got[g] = '0;
    end
    lat = lat_i;
    n = 0;
    while (!(req_ready[0] && req_ready[1]) && n < 200) begin @(negedge clk); n++; end
    chk({nm, " ready"}, 32'(req_ready[0] && req_ready[1]), 32'd1);
    for (int g = 0; g < 2; g++) begin m0[g] = mcnt[g]; d0[g] = dcnt[g]; end
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b;
    @(negedge clk);
    req_valid = 1'b0;
    tail = -1;
    for (int k = 0; k < 300 && tail != 0; k++) begin
      done = 1'b1;
      for (int g = 0; g < 2; g++) begin
        if (resp_valid[g]) begin nresp[g]++; got[g] = resp_data[g]; rlat[g] = k + 1; end
        if (!fast[g] && fl_dly >= 0 && req_ready[g] && !comp[g]) early[g] = 1'b1;
        if (mul_completed[g] || div_completed[g]) comp[g] = 1'b1;
        if (nresp[g] < int'(want[g]) || !req_ready[g]) done = 1'b0;
      end
      if (tail < 0 && done) tail = 3;
      else if (tail > 0) tail--;
      flush = (k == fl_dly);
      @(negedge clk);
    end
    flush = 1'b0;
    chk({nm, " finished"}, 32'(tail), 32'd0);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("%s[%0d] resp count", nm, g), nresp[g], 32'(want[g]));
      if (want[g]) chk($sformatf("%s[%0d] data", nm, g), got[g], exp);
      if (fast[g]) begin
        chk($sformatf("%s[%0d] fast latency", nm, g), rlat[g], 32'd1);
        chk($sformatf("%s[%0d] core starts", nm, g), (mcnt[g] - m0[g]) + (dcnt[g] - d0[g]), 32'd0);
      end else begin
        chk($sformatf("%s[%0d] mul starts", nm, g), mcnt[g] - m0[g], op[2] ? 32'd0 : 32'd1);
        chk($sformatf("%s[%0d] div starts", nm, g), dcnt[g] - d0[g], op[2] ? 32'd1 : 32'd0);
      end
      if (!fast[g] && fl_dly >= 0)
        chk($sformatf("%s[%0d] ready before drain", nm, g), 32'(early[g]), 32'd0);
    end
    if (op[2] && !spec && fl_dly < 0) begin
      c_vld = 1'b1; c_rs1 = a; c_rs2 = b; c_sgn = !op[0];
    end
    got0 = got[0];
    st0  = (mcnt[0] - m0[0]) + (dcnt[0] - d0[0]);
    st1  = (mcnt[1] - m0[1]) + (dcnt[1] - d0[1]);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, exp;
    bit          fast0, fast1, chk_ab;
    logic [31:0] ma, mb;
  } vec_t;

  vec_t vt[10];

  initial begin
    logic [31:0] got0, a, b, pa, pb;
    logic [2:0]  op;
    int          st0, st1, nr, l, f, r;

    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] got0, a, b, pa, pb;
    logic [2:0]  op;
    int          st0, st1, nr, l, f, r;

    vt[0] = '{3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0};
    vt[1] = '{3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0};
    vt[2] = '{3'd5, 32'd5,         32'd0,        32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0};
    vt[3] = '{3'd7, 32'd5,         32'd0,        32'd5,         1'b1, 1'b1, 1'b0, 32'd0, 32'd0};
    vt[4] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 32'd0, 32'd0};
    vt[5] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        1'b1, 1'b1, 1'b0, 32'd0, 32'd0};
    vt[6] = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,        1'b0, 1'b0, 1'b1, 32'd1, 32'd1};
    vt[7] = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    vt[8] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'd1, 32'hFFFF_FFFF};
    vt[9] = '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,        1'b0, 1'b0, 1'b1, 32'd1, 32'd1};

    // Reset state
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("reset[%0d] resp_valid", g), 32'(resp_valid[g]), 32'd0);
      chk($sformatf("reset[%0d] resp_data", g), resp_data[g], 32'd0);
      chk($sformatf("reset[%0d] req_ready", g), 32'(req_ready[g]), 32'd1);
      chk($sformatf("reset[%0d] enables", g), 32'({mul_enable[g], div_enable[g]}), 32'd0);
      chk($sformatf("reset[%0d] div_divisor", g), div_divisor[g], 32'd1);
    end
    rstn = 1'b1;
    @(negedge clk);

    // Directed table
    for (int i = 0; i < 10; i++) begin
      do_req($sformatf("vec%0d", i), vt[i].op, vt[i].a, vt[i].b, -1, (i % 2) ? 34 : 1, got0, st0, st1);
      chk($sformatf("vec%0d table data", i), got0, vt[i].exp);
      chk($sformatf("vec%0d starts cache", i), st0, vt[i].fast0 ? 32'd0 : 32'd1);
      chk($sformatf("vec%0d starts nocache", i), st1, vt[i].fast1 ? 32'd0 : 32'd1);
      if (vt[i].chk_ab) begin
        chk($sformatf("vec%0d mul_a", i), mul_a[0], vt[i].ma);
        chk($sformatf("vec%0d mul_b", i), mul_b[0], vt[i].mb);
      end
    end

    // Flush in DIV_WAIT, then the same operands must miss the cache
    do_req("prime", 3'd4, 32'd100, 32'd7, -1, 3, got0, st0, st1);
    do_req("flushdiv", 3'd4, 32'h1234, 32'h11, 1, 34, got0, st0, st1);
    do_req("afterflush", 3'd4, 32'h1234, 32'h11, -1, 2, got0, st0, st1);
    chk("afterflush cache miss", st0, 32'd1);
    chk("afterflush data", got0, 32'h0000_0112);
    do_req("afterflush hit", 3'd6, 32'h1234, 32'h11, -1, 2, got0, st0, st1);
    chk("afterflush hit starts", st0, 32'd0);

    // Reset during MUL_WAIT with a late done pulse
    lat = 20;
    req_valid = 1'b1; req_op = 3'd1; req_rs1 = 32'h1234_5678; req_rs2 = 32'h9ABC_DEF0;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    nr = 0;
    repeat (30) begin
      @(negedge clk);
      nr += int'(resp_valid[0]) + int'(resp_valid[1]);
    end
    c_vld = 1'b0;
    chk("rst mid-op resp count", nr, 32'd0);
    for (int g = 0; g < 2; g++) begin
      chk($sformatf("rst mid-op[%0d] ready", g), 32'(req_ready[g]), 32'd1);
      chk($sformatf("rst mid-op[%0d] resp_data", g), resp_data[g], 32'd0);
      chk($sformatf("rst mid-op[%0d] mul ops", g), {mul_a[g] | mul_b[g]}, 32'd0);
      chk($sformatf("rst mid-op[%0d] div ops", g), div_dividend[g] + div_divisor[g], 32'd1);
      chk($sformatf("rst mid-op[%0d] enables", g), 32'({mul_enable[g], div_enable[g]}), 32'd0);
    end

    // Randomized against the reference model
    pa = '0; pb = '0;
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      if (i > 0 && $urandom_range(0, 2) == 0) begin a = pa; b = pb; end
      else begin a = pick(); b = pick(); end
      r = $urandom_range(0, 3);
      l = (r == 0) ? 1 : (r == 1) ? 34 : $urandom_range(1, 8);
      f = ($urandom_range(0, 6) == 0) ? $urandom_range(0, 2) : -1;
      do_req($sformatf("rnd%0d", i), op, a, b, f, l, got0, st0, st1);
      pa = a; pb = b;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
